// File: rtl/cpu_mem_bridge_pkg.sv
// Shared FSM state type and constants for the gm64 CPU-to-PSRAM bridge.
package gm64_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE,
      ACK
   } bridgeState_e;

   localparam logic [3:0]  MEM_NBYTES_SINGLE = 4'd1;
   localparam logic [7:0]  ABORT_RDATA       = 8'hFF;
   localparam logic [15:0] BORDER_ADDR       = 16'hD020;

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// memCtrl transaction bus: the bridge is the master, the memory controller is the slave.
interface cpu_mem_bridge_if;

   logic        mem_ce;
   logic        mem_write;
   logic [6:0]  mem_bank;
   logic [15:0] mem_addr;
   logic [3:0]  mem_nbytes;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_busy;

   modport master (
      output mem_ce, mem_write, mem_bank, mem_addr, mem_nbytes, mem_wdata,
      input  mem_rdata, mem_busy
   );

   modport slave (
      input  mem_ce, mem_write, mem_bank, mem_addr, mem_nbytes, mem_wdata,
      output mem_rdata, mem_busy
   );

endinterface

// File: rtl/cpu_mem_bridge_toggle_sync.sv
// Toggle synchroniser: SYNC_STAGES flop chain with asynchronous active-low reset.
// Also used on the CPU side to bring cpu_ack_tgl back into the clk0 domain.
module toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cpu_mem_bridge.sv
// Single-byte CPU (clk0) to memCtrl (clkRAM) bridge using a req/ack toggle handshake.
// Optional BORDER_TAP_EN adds border_col_o, the VIC debug colour taken from writes to $D020.
module cpu_mem_bridge
   import gm64_bus_pkg::*;
#(
   parameter logic [6:0] DEFAULT_BANK   = 7'd0,
   parameter int         TIMEOUT_CYCLES = 255,
   parameter int         SYNC_STAGES    = 2
) (
   input  logic             clkRAM,
   input  logic             reset,
   input  logic             cpu_req_tgl_i,
   input  logic [15:0]      cpu_addr_i,
   input  logic             cpu_we_i,
   input  logic [7:0]       cpu_wdata_i,
   output logic             cpu_ack_tgl_o,
   output logic [7:0]       cpu_rdata_o,
   output logic             cpu_rdy_o,
   input  logic             bank_we_i,
   input  logic [6:0]       bank_in_i,
`ifdef BORDER_TAP_EN
   output logic [3:0]       border_col_o,
`endif
   output logic             err_o,
   cpu_mem_bridge_if.master mem
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   bridgeState_e state_q, state_d;
   logic         reqSync;
   logic         pending;
   logic         ackTgl_q, ackTgl_d;
   logic         rdy_q;
   logic [7:0]   rdata_q, rdata_d;
   logic         err_q, err_d;
   logic [7:0]   cnt_q, cnt_d, cntInc;
   logic         timeoutHit;
   logic [15:0]  addr_q, addr_d;
   logic         write_q, write_d;
   logic [7:0]   wdata_q, wdata_d;
   logic [6:0]   bank_q;
   logic [6:0]   memBank_q, memBank_d;

   toggle_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_reqSync (
      .clock(clkRAM),
      .reset(reset),
      .d_i  (cpu_req_tgl_i),
      .q_o  (reqSync)
   );

   assign pending    = reqSync ^ ackTgl_q;
   assign cntInc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   assign timeoutHit = (cnt_q == TIMEOUT_LIMIT);

   always_ff @(posedge clkRAM or negedge reset) begin
      if (!reset) begin
         bank_q <= DEFAULT_BANK;
      end else if (bank_we_i) begin
         bank_q <= bank_in_i;
      end
   end

   always_ff @(posedge clkRAM or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ackTgl_q  <= 1'b0;
         rdy_q     <= 1'b1;
         rdata_q   <= 8'h00;
         err_q     <= 1'b0;
         cnt_q     <= 8'h00;
         addr_q    <= 16'h0000;
         write_q   <= 1'b0;
         wdata_q   <= 8'h00;
         memBank_q <= DEFAULT_BANK;
      end else begin
         state_q   <= state_d;
         ackTgl_q  <= ackTgl_d;
         rdy_q     <= !pending;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         memBank_q <= memBank_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ackTgl_d  = ackTgl_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      memBank_d = memBank_q;
      case (state_q)
         IDLE: begin
            // The bank is captured alongside the address so a later bank_we cannot disturb this transaction.
            if (pending && !mem.mem_busy) begin
               addr_d    = cpu_addr_i;
               write_d   = cpu_we_i;
               wdata_d   = cpu_wdata_i;
               memBank_d = bank_q;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = 8'h00;
            state_d = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            cnt_d = cntInc;
            if (mem.mem_busy) begin
               state_d = WAIT_DONE;
            end else if (timeoutHit) begin
               err_d   = 1'b1;
               rdata_d = write_q ? rdata_q : ABORT_RDATA;
               state_d = ACK;
            end
         end
         WAIT_DONE: begin
            cnt_d = cntInc;
            if (!mem.mem_busy) begin
               rdata_d = write_q ? rdata_q : mem.mem_rdata;
               state_d = ACK;
            end else if (timeoutHit) begin
               err_d   = 1'b1;
               rdata_d = write_q ? rdata_q : ABORT_RDATA;
               state_d = ACK;
            end
         end
         ACK: begin
            ackTgl_d = ~ackTgl_q;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef BORDER_TAP_EN
   logic [3:0] border_q;

   always_ff @(posedge clkRAM or negedge reset) begin
      if (!reset) begin
         border_q <= 4'h0;
      end else if (state_q == ACK && write_q && addr_q == BORDER_ADDR) begin
         border_q <= wdata_q[3:0];
      end
   end

   assign border_col_o = border_q;
`endif

   assign mem.mem_ce     = (state_q == ISSUE);
   assign mem.mem_write  = write_q;
   assign mem.mem_bank   = memBank_q;
   assign mem.mem_addr   = addr_q;
   assign mem.mem_nbytes = MEM_NBYTES_SINGLE;
   assign mem.mem_wdata  = wdata_q;

   assign cpu_ack_tgl_o = ackTgl_q;
   assign cpu_rdata_o   = rdata_q;
   assign cpu_rdy_o     = rdy_q;
   assign err_o         = err_q;

endmodule
